// File: rtl/taxi_eth_tx_tag_tracker_if.sv
// rtl/taxi_eth_tx_tag_tracker_if.sv - AXI-Stream bundle shared by the TX tag tracker ports
interface taxi_axis_if #(
  parameter int DATA_W = 8,
  parameter int KEEP_W = (DATA_W + 7) / 8,
  parameter int ID_W   = 1,
  parameter int USER_W = 1
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [USER_W-1:0] tuser;

  modport src    (output tdata, tkeep, tvalid, tlast, tid, tuser, input  tready);
  modport snk    (input  tdata, tkeep, tvalid, tlast, tid, tuser, output tready);
  modport master (output tdata, tkeep, tvalid, tlast, tid, tuser, input  tready);
  modport slave  (input  tdata, tkeep, tvalid, tlast, tid, tuser, output tready);
endinterface

// File: rtl/taxi_eth_tx_tag_tracker.sv
// rtl/taxi_eth_tx_tag_tracker.sv - tags TX frames, matches MAC completions, reports latency
module taxi_eth_tx_tag_tracker #(
  parameter int              TAG_W   = 4,
  parameter int              LAT_W   = 32,
  parameter longint unsigned TIMEOUT = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  taxi_axis_if.snk        s_axis,
  taxi_axis_if.src        m_axis,
  taxi_axis_if.snk        s_axis_cpl,
  taxi_axis_if.src        m_axis_cpl,
  output logic [TAG_W:0]  stat_outstanding,
  output logic            stat_cpl_unexpected,
  output logic            stat_timeout
);
  localparam int N  = 2 ** TAG_W;
  localparam int CW = TAG_W + 1;
  localparam logic [LAT_W-1:0] TIMEOUT_L = LAT_W'(TIMEOUT);

  typedef enum logic {ST_IDLE, ST_FRAME} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [N-1:0]     r_inflight;
  logic [N-1:0]     w_inflight_next;
  logic [LAT_W-1:0] r_ts_start [N];
  logic [TAG_W-1:0] r_next_tag;
  logic [TAG_W-1:0] r_scan_ptr;
  logic [LAT_W-1:0] r_timer;
  logic             r_cpl_valid;
  logic [TAG_W-1:0] r_cpl_tid;
  logic [LAT_W-1:0] r_cpl_lat;
  logic [CW-1:0]    r_outstanding;
  logic             r_stat_unexp;
  logic             r_stat_timeout;

  logic             w_block;
  logic             w_beat;
  logic             w_alloc;
  logic             w_frame_end;
  logic             w_cpl_rdy;
  logic             w_cpl_acc;
  logic             w_cpl_hit;
  logic             w_cpl_miss;
  logic             w_timeout;
  logic [TAG_W-1:0] w_cpl_tag;
  logic [LAT_W-1:0] w_scan_age;
  logic             w_unused;

  // Only a frame's first beat can stall on tag state; later beats always flow.
  assign w_block       = (r_state == ST_IDLE) && r_inflight[r_next_tag];
  assign w_beat        = s_axis.tvalid && m_axis.tready && !w_block;
  assign w_alloc       = w_beat && (r_state == ST_IDLE);
  assign w_frame_end   = w_beat && s_axis.tlast;

  assign m_axis.tvalid = s_axis.tvalid && !w_block;
  assign s_axis.tready = m_axis.tready && !w_block;
  assign m_axis.tdata  = s_axis.tdata;
  assign m_axis.tkeep  = s_axis.tkeep;
  assign m_axis.tlast  = s_axis.tlast;
  assign m_axis.tuser  = s_axis.tuser;
  assign m_axis.tid    = r_next_tag;

  assign w_cpl_rdy         = !r_cpl_valid || m_axis_cpl.tready;
  assign s_axis_cpl.tready = w_cpl_rdy;
  assign w_cpl_tag         = s_axis_cpl.tid;
  assign w_cpl_acc         = s_axis_cpl.tvalid && w_cpl_rdy;
  assign w_cpl_hit         = w_cpl_acc && r_inflight[w_cpl_tag];
  assign w_cpl_miss        = w_cpl_acc && !r_inflight[w_cpl_tag];

  // The scan pauses while a completion is accepted so the two never clear the same cycle.
  assign w_scan_age = r_timer - r_ts_start[r_scan_ptr];
  assign w_timeout  = !w_cpl_acc && r_inflight[r_scan_ptr] && (w_scan_age >= TIMEOUT_L);

  assign m_axis_cpl.tvalid = r_cpl_valid;
  assign m_axis_cpl.tdata  = r_cpl_lat;
  assign m_axis_cpl.tid    = r_cpl_tid;
  assign m_axis_cpl.tkeep  = '1;
  assign m_axis_cpl.tlast  = 1'b1;
  assign m_axis_cpl.tuser  = '0;

  assign stat_outstanding    = r_outstanding;
  assign stat_cpl_unexpected = r_stat_unexp;
  assign stat_timeout        = r_stat_timeout;

  assign w_unused = ^{s_axis.tid, s_axis_cpl.tdata, s_axis_cpl.tkeep,
                      s_axis_cpl.tlast, s_axis_cpl.tuser};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_beat && !s_axis.tlast) w_state_next = ST_FRAME;
      ST_FRAME: if (w_frame_end)             w_state_next = ST_IDLE;
      default:                               w_state_next = ST_IDLE;
    endcase
  end

  // Allocation, match and timeout always target distinct tags, so order is irrelevant.
  always_comb begin
    w_inflight_next = r_inflight;
    if (w_alloc)   w_inflight_next[r_next_tag] = 1'b1;
    if (w_cpl_hit) w_inflight_next[w_cpl_tag]  = 1'b0;
    if (w_timeout) w_inflight_next[r_scan_ptr] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_inflight     <= '0;
      r_next_tag     <= '0;
      r_scan_ptr     <= '0;
      r_timer        <= '0;
      r_cpl_valid    <= 1'b0;
      r_outstanding  <= '0;
      r_stat_unexp   <= 1'b0;
      r_stat_timeout <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_inflight     <= w_inflight_next;
      r_timer        <= r_timer + 1'b1;
      r_stat_unexp   <= w_cpl_miss;
      r_stat_timeout <= w_timeout;
      r_outstanding  <= r_outstanding + CW'(w_alloc) - CW'(w_cpl_hit) - CW'(w_timeout);
      if (w_frame_end) r_next_tag <= r_next_tag + 1'b1;
      if (!w_cpl_acc)  r_scan_ptr <= r_scan_ptr + 1'b1;
      if (w_cpl_hit)
        r_cpl_valid <= 1'b1;
      else if (m_axis_cpl.tready)
        r_cpl_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc) r_ts_start[r_next_tag] <= r_timer;
    if (w_cpl_hit) begin
      r_cpl_tid <= w_cpl_tag;
      r_cpl_lat <= r_timer - r_ts_start[w_cpl_tag];
    end
  end
endmodule

// File: tb/tb_taxi_eth_tx_tag_tracker.sv
// tb/tb_taxi_eth_tx_tag_tracker.sv - self-checking bench for the TX tag tracker
module tb_taxi_eth_tx_tag_tracker;
  logic clk;
  logic rst;
  logic [2:0] stat_out, t_stat_out;
  logic stat_unexp, stat_to, t_stat_unexp, t_stat_to;

  taxi_axis_if #(.DATA_W(8))                          s_if();
  taxi_axis_if #(.DATA_W(8), .ID_W(2))                m_if();
  taxi_axis_if #(.DATA_W(8), .ID_W(2))                sc_if();
  taxi_axis_if #(.DATA_W(32), .KEEP_W(1), .ID_W(2))   mc_if();
  taxi_axis_if #(.DATA_W(8))                          t_s_if();
  taxi_axis_if #(.DATA_W(8), .ID_W(2))                t_m_if();
  taxi_axis_if #(.DATA_W(8), .ID_W(2))                t_sc_if();
  taxi_axis_if #(.DATA_W(32), .KEEP_W(1), .ID_W(2))   t_mc_if();

  taxi_eth_tx_tag_tracker #(.TAG_W(2), .LAT_W(32), .TIMEOUT(1000)) u_dut (
    .clk(clk), .rst(rst), .s_axis(s_if), .m_axis(m_if),
    .s_axis_cpl(sc_if), .m_axis_cpl(mc_if),
    .stat_outstanding(stat_out), .stat_cpl_unexpected(stat_unexp), .stat_timeout(stat_to)
  );

  taxi_eth_tx_tag_tracker #(.TAG_W(2), .LAT_W(32), .TIMEOUT(20)) u_dut_to (
    .clk(clk), .rst(rst), .s_axis(t_s_if), .m_axis(t_m_if),
    .s_axis_cpl(t_sc_if), .m_axis_cpl(t_mc_if),
    .stat_outstanding(t_stat_out), .stat_cpl_unexpected(t_stat_unexp), .stat_timeout(t_stat_to)
  );

  typedef struct {
    logic       valid;
    logic       last;
    logic [7:0] data;
    logic       exp_ready;
    logic [1:0] exp_tid;
    int         exp_out;
  } vec_t;

  typedef struct {
    logic [1:0]  tid;
    logic [31:0] lat;
  } cpl_t;

  vec_t        vecs [5];
  cpl_t        sb [$];
  logic [31:0] ts_model [4];
  logic [31:0] m_timer;
  logic [1:0]  ctags [3];
  int          checks;
  int          failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) m_timer <= 32'd0;
    else     m_timer <= m_timer + 32'd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_cpl(input logic [1:0] tid);
    cpl_t e;
    e.tid = tid;
    e.lat = m_timer - ts_model[tid];
    sb.push_back(e);
  endtask

  task automatic mon();
    cpl_t e;
    if (mc_if.tvalid && mc_if.tready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL cpl_spurious: got tid %0d expected no completion", mc_if.tid);
      end else begin
        e = sb.pop_front();
        chk("cpl_tid", mc_if.tid, e.tid);
        chk("cpl_latency", mc_if.tdata, e.lat);
        chk("cpl_tlast", mc_if.tlast, 1);
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
    mon();
  endtask

  task automatic fin();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int k;
    int seen;
    int npulse;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    s_if.tvalid = 0; s_if.tlast = 0; s_if.tdata = 0; s_if.tkeep = 1; s_if.tuser = 0; s_if.tid = 0;
    m_if.tready = 1;
    sc_if.tvalid = 0; sc_if.tid = 0; sc_if.tdata = 0; sc_if.tkeep = 1; sc_if.tlast = 1; sc_if.tuser = 0;
    mc_if.tready = 1;
    t_s_if.tvalid = 0; t_s_if.tlast = 0; t_s_if.tdata = 0; t_s_if.tkeep = 1; t_s_if.tuser = 0; t_s_if.tid = 0;
    t_m_if.tready = 1;
    t_sc_if.tvalid = 0; t_sc_if.tid = 0; t_sc_if.tdata = 0; t_sc_if.tkeep = 1; t_sc_if.tlast = 1; t_sc_if.tuser = 0;
    t_mc_if.tready = 1;

    vecs[0] = '{1'b1, 1'b1, 8'hA0, 1'b1, 2'd0, 0};
    vecs[1] = '{1'b1, 1'b1, 8'hA1, 1'b1, 2'd1, 1};
    vecs[2] = '{1'b1, 1'b1, 8'h5A, 1'b1, 2'd2, 2};
    vecs[3] = '{1'b1, 1'b1, 8'hC3, 1'b1, 2'd3, 3};
    vecs[4] = '{1'b1, 1'b1, 8'hEE, 1'b0, 2'd0, 4};
    ctags[0] = 2'd1; ctags[1] = 2'd2; ctags[2] = 2'd3;

    repeat (3) fin();
    half();
    chk("rst_outstanding", stat_out, 0);
    chk("rst_cpl_valid", mc_if.tvalid, 0);
    chk("rst_unexpected", stat_unexp, 0);
    chk("rst_timeout", stat_to, 0);
    chk("rst_tid", m_if.tid, 0);
    fin();
    rst = 1'b0;

    // Four single-beat frames fill every tag, the fifth stalls.
    for (int i = 0; i < 5; i++) begin
      s_if.tvalid = vecs[i].valid;
      s_if.tlast  = vecs[i].last;
      s_if.tdata  = vecs[i].data;
      half();
      chk("tbl_s_ready", s_if.tready, vecs[i].exp_ready);
      chk("tbl_m_valid", m_if.tvalid, vecs[i].exp_ready);
      chk("tbl_tid", m_if.tid, vecs[i].exp_tid);
      chk("tbl_tdata", m_if.tdata, vecs[i].data);
      chk("tbl_tlast", m_if.tlast, vecs[i].last);
      chk("tbl_outstanding", stat_out, vecs[i].exp_out);
      if (vecs[i].exp_ready) ts_model[vecs[i].exp_tid] = m_timer;
      fin();
    end

    sc_if.tvalid = 1; sc_if.tid = 2'd0;
    half();
    chk("blk_same_cycle", s_if.tready, 0);
    chk("cpl_ready_idle", sc_if.tready, 1);
    push_cpl(2'd0);
    fin();
    sc_if.tvalid = 0;
    half();
    chk("realloc_ready", s_if.tready, 1);
    chk("realloc_tid", m_if.tid, 0);
    chk("realloc_out", stat_out, 3);
    ts_model[0] = m_timer;
    fin();
    s_if.tvalid = 0;
    half();
    chk("full_again_out", stat_out, 4);
    fin();

    // Completion output stalled for 10 cycles while three completions are offered.
    mc_if.tready = 0;
    sc_if.tvalid = 1;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      sc_if.tid = ctags[k];
      half();
      chk("bp_cpl_ready", sc_if.tready, (c == 0));
      if (c == 9) begin
        chk("bp_held_valid", mc_if.tvalid, 1);
        chk("bp_held_tid", mc_if.tid, 1);
      end
      if (c == 0) begin
        push_cpl(ctags[k]);
        k++;
      end
      fin();
    end
    mc_if.tready = 1;
    while (k < 3) begin
      sc_if.tid = ctags[k];
      half();
      chk("bp_resume_ready", sc_if.tready, 1);
      push_cpl(ctags[k]);
      k++;
      fin();
    end
    sc_if.tvalid = 0;
    for (int g = 0; g < 5 && sb.size() > 0; g++) begin
      half();
      fin();
    end
    chk("bp_drained", sb.size(), 0);
    half();
    chk("bp_outstanding", stat_out, 1);
    fin();

    // Completion for an idle tag.
    sc_if.tvalid = 1; sc_if.tid = 2'd3;
    half();
    fin();
    sc_if.tvalid = 0;
    half();
    chk("unexp_pulse", stat_unexp, 1);
    chk("unexp_no_cpl", mc_if.tvalid, 0);
    chk("unexp_out", stat_out, 1);
    fin();
    half();
    chk("unexp_single", stat_unexp, 0);
    fin();

    // First beat accepted at timer 100, completion at 150.
    for (int g = 0; g < 200 && m_timer != 32'd100; g++) begin
      half();
      fin();
    end
    s_if.tvalid = 1; s_if.tlast = 1; s_if.tdata = 8'h77;
    half();
    chk("lat_timer_start", m_timer, 100);
    chk("lat_alloc_ready", s_if.tready, 1);
    chk("lat_alloc_tid", m_if.tid, 1);
    ts_model[1] = m_timer;
    fin();
    s_if.tvalid = 0;
    for (int g = 0; g < 200 && m_timer != 32'd150; g++) begin
      half();
      fin();
    end
    sc_if.tvalid = 1; sc_if.tid = 2'd1;
    half();
    begin
      cpl_t e;
      e.tid = 2'd1;
      e.lat = 32'd50;
      sb.push_back(e);
    end
    chk("lat_cpl_idle_before", mc_if.tvalid, 0);
    fin();
    sc_if.tvalid = 0;
    half();
    chk("lat_cpl_valid_next", mc_if.tvalid, 1);
    fin();
    half();
    chk("lat_sb_empty", sb.size(), 0);
    fin();

    // Reset during beat 3 of a 10-beat frame.
    s_if.tvalid = 1; s_if.tlast = 0;
    for (int b = 0; b < 2; b++) begin
      s_if.tdata = 8'(b);
      half();
      chk("frame_tid_const", m_if.tid, 2);
      fin();
    end
    rst = 1'b1;
    half();
    fin();
    rst = 1'b0;
    s_if.tlast = 1;
    half();
    chk("post_rst_out", stat_out, 0);
    chk("post_rst_tid", m_if.tid, 0);
    chk("post_rst_ready", s_if.tready, 1);
    chk("post_rst_timer", m_timer, 0);
    ts_model[0] = m_timer;
    fin();
    s_if.tvalid = 0;
    half();
    chk("post_rst_alloc_out", stat_out, 1);
    chk("post_rst_next_tid", m_if.tid, 1);
    fin();
    repeat (4) begin
      half();
      fin();
    end
    sc_if.tvalid = 1; sc_if.tid = 2'd0;
    half();
    push_cpl(2'd0);
    fin();
    sc_if.tvalid = 0;
    half();
    fin();
    chk("post_rst_sb_empty", sb.size(), 0);

    // Timeout instance: one tag left outstanding.
    t_s_if.tvalid = 1; t_s_if.tlast = 1;
    half();
    chk("to_alloc_ready", t_s_if.tready, 1);
    fin();
    t_s_if.tvalid = 0;
    seen = -1;
    npulse = 0;
    for (int i = 0; i < 25; i++) begin
      half();
      if (t_stat_to) begin
        npulse++;
        if (seen < 0) seen = i;
      end
      fin();
    end
    chk("to_pulse_count", npulse, 1);
    chk("to_pulse_not_early", (seen >= 20), 1);
    half();
    chk("to_outstanding", t_stat_out, 0);
    fin();
    t_sc_if.tvalid = 1; t_sc_if.tid = 2'd0;
    half();
    fin();
    t_sc_if.tvalid = 0;
    half();
    chk("to_late_unexp", t_stat_unexp, 1);
    chk("to_late_no_cpl", t_mc_if.tvalid, 0);
    chk("to_late_out", t_stat_out, 0);
    chk("main_no_timeout", stat_to, 0);
    fin();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/taxi_eth_tx_tag_tracker.md
TAXI_ETH_TX_TAG_TRACKER -- requirements
Module: taxi_eth_tx_tag_tracker

Interface
REQ-001 Parameters SHALL be: TAG_W, default 4, tag width (equals m_axis.ID_W); LAT_W, default 32, latency/timer width; TIMEOUT, default 1000000, reclaim threshold in cycles (< 2^LAT_W, >= 1).
REQ-002 Ports SHALL be: clk  in  1  sole clock; rst  in  1  reset, synchronous, active-high.
REQ-003 s_axis  taxi_axis_if.snk  8-bit data, 1-bit tuser  untagged TX frames from user logic.
REQ-004 m_axis  taxi_axis_if.src  8-bit data, 1-bit tuser, ID_W=TAG_W  tagged TX frames to the MAC TX FIFO.
REQ-005 s_axis_cpl  taxi_axis_if.snk  ID_W=TAG_W  TX completions returned by the MAC; tdata ignored.
REQ-006 m_axis_cpl  taxi_axis_if.src  DATA_W=LAT_W, KEEP_W=1, ID_W=TAG_W  matched completions; tdata = latency, tid = tag, tlast = 1.
REQ-007 stat_outstanding  out  TAG_W+1  number of tags currently in flight.
REQ-008 stat_cpl_unexpected  out  1  one-cycle pulse: completion for a tag not in flight.
REQ-009 stat_timeout  out  1  one-cycle pulse: tag reclaimed by timeout.

Function
REQ-010 State SHALL be: inflight[2^TAG_W] bits, ts_start[2^TAG_W] x LAT_W, next_tag (TAG_W), frame_active flag, free-running timer (LAT_W, +1 every cycle, wraps), scan_ptr (TAG_W), output register for m_axis_cpl.
REQ-011 Frame path SHALL be combinational pass-through: m_axis.tdata/tkeep/tlast/tuser = s_axis fields; m_axis.tid = next_tag.
REQ-012 block = !frame_active && inflight[next_tag]; m_axis.tvalid = s_axis.tvalid && !block; s_axis.tready = m_axis.tready && !block.
REQ-013 On accepted first beat (!frame_active): inflight[next_tag] <= 1, ts_start[next_tag] <= timer, frame_active <= !tlast.
REQ-014 On accepted beat with tlast: next_tag <= next_tag + 1 (wraps mod 2^TAG_W), frame_active <= 0.
REQ-015 A frame once started SHALL never be stalled by tag state; tid stays constant for all beats of a frame.
REQ-016 s_axis_cpl.tready = !m_axis_cpl.tvalid || m_axis_cpl.tready (one-stage output register, full throughput).
REQ-017 On accepted completion with inflight[tid] = 1: clear inflight[tid]; next cycle m_axis_cpl.tvalid = 1, tid = tid, tdata = (timer - ts_start[tid]) mod 2^LAT_W.
REQ-018 On accepted completion with inflight[tid] = 0: no output, no state change, stat_cpl_unexpected = 1 the next cycle.
REQ-019 Timeout scan: each cycle, if inflight[scan_ptr] && (timer - ts_start[scan_ptr]) >= TIMEOUT, clear inflight[scan_ptr] and pulse stat_timeout next cycle; scan_ptr += 1 (wraps).
REQ-020 The scan SHALL hold (no check, no increment) on any cycle a completion is accepted.
REQ-021 Same-cycle events: block uses the pre-cycle inflight value. A completion clearing next_tag lets allocation proceed the following cycle. A completion for a tag being allocated in the same cycle is unexpected.
REQ-022 stat_outstanding SHALL be registered: previous value + allocations - matched completions - timeouts, range 0..2^TAG_W.
REQ-023 Latency SHALL be measured first-beat acceptance to completion acceptance; for a 1-cycle gap it is 1.

Reset
REQ-024 While rst = 1 at a clk edge: inflight all 0, next_tag 0, frame_active 0, timer 0, scan_ptr 0, m_axis_cpl.tvalid 0, stat_* 0. ts_start need not be reset.
REQ-025 Reset mid-frame SHALL abandon the frame; the next accepted beat after reset is treated as a first beat with tid 0.
REQ-026 During reset, s_axis.tready and s_axis_cpl.tready are don't-care; no transfers are counted.

Verification
REQ-027 TAG_W=2: send 4 single-beat frames, no completions -> tids 0,1,2,3, stat_outstanding = 4; 5th frame stalled (tready = 0); complete tag 0 -> 5th frame sent with tid 0 one cycle later.
REQ-028 Frame first beat accepted at timer = 100, completion accepted at timer = 150 -> m_axis_cpl tdata = 50, tid matches, tvalid asserted on the cycle after acceptance.
REQ-029 Completion tid = 3 with tag 3 idle -> stat_cpl_unexpected pulses once, m_axis_cpl stays idle, stat_outstanding unchanged.
REQ-030 TIMEOUT = 20, TAG_W=2, one tag outstanding, no completion -> stat_timeout pulses within 20+4 cycles, stat_outstanding returns to 0; a later completion for that tag -> unexpected.
REQ-031 m_axis_cpl.tready = 0 for 10 cycles with 3 completions offered -> one completion held, s_axis_cpl stalled, none lost; all 3 emitted in order once tready = 1.
REQ-032 Assert rst during beat 3 of a 10-beat frame -> after reset stat_outstanding = 0; the next frame carries tid 0; timer restarts from 0.
